smac_accum: RTL and testbench

//  Sequential signed accumulate stage fed by the smult4bit array multiplier's product p.

---
 rtl/smac_pkg.sv | 23 ++
 rtl/smac_accum_if.sv | 28 ++
 rtl/sat_add.sv | 40 ++++
 rtl/smac_accum.sv | 95 +++++++++
 tb/tb_smac_accum.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/smac_pkg.sv
// smac_pkg: shared definitions for the signed multiply-accumulate datapath.
//   - FSM state encodings for the accumulate stage
//   - default product width (output of the 4x4 signed multiplier)
//   - saturation limits of a signed ACC_W-bit result
package smac_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int PROD_W_DEF = 8;

    // Largest value representable in a signed acc_w-bit word.
    function automatic int sat_max(input int acc_w);
        return (1 << (acc_w - 1)) - 1;
    endfunction

    // Smallest value representable in a signed acc_w-bit word.
    function automatic int sat_min(input int acc_w);
        return -(1 << (acc_w - 1));
    endfunction

endpackage

// File: rtl/smac_accum_if.sv
// smac_accum_if: handshake bundle around the accumulate stage.
//   start, p_in, p_valid, acc_ready : driven by the master (upstream/downstream side)
//   p_ready, acc_out, acc_valid,
//   busy, ovf                       : driven by the slave (the accumulate stage)
interface smac_accum_if #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 10
);
    logic                     start;
    logic signed [PROD_W-1:0] p_in;
    logic                     p_valid;
    logic                     p_ready;
    logic signed [ACC_W-1:0]  acc_out;
    logic                     acc_valid;
    logic                     acc_ready;
    logic                     busy;
    logic                     ovf;

    modport master (
        output start, p_in, p_valid, acc_ready,
        input  p_ready, acc_out, acc_valid, busy, ovf
    );

    modport slave (
        input  start, p_in, p_valid, acc_ready,
        output p_ready, acc_out, acc_valid, busy, ovf
    );
endinterface

// File: rtl/sat_add.sv
// sat_add: combinational signed add with saturation.
//   a    in  ACC_W   signed running value
//   b    in  PROD_W  signed addend (sign-extended, PROD_W <= ACC_W)
//   sum  out ACC_W   a+b clamped to the signed ACC_W range
//   ovf  out 1       the clamp was applied
module sat_add
    import smac_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = 10
) (
    input  logic signed [ACC_W-1:0]  a,
    input  logic signed [PROD_W-1:0] b,
    output logic signed [ACC_W-1:0]  sum,
    output logic                     ovf
);
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(sat_max(ACC_W));
    localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(sat_min(ACC_W));

    logic signed [ACC_W:0] a_ext;
    logic signed [ACC_W:0] b_ext;
    logic signed [ACC_W:0] sum_wide;

    // One guard bit is enough: both operands fit in ACC_W bits, so the
    // exact sum always fits in ACC_W+1 bits.
    always_comb begin
        a_ext    = {a[ACC_W-1], a};
        b_ext    = {{(ACC_W+1-PROD_W){b[PROD_W-1]}}, b};
        sum_wide = a_ext + b_ext;
        sum      = sum_wide[ACC_W-1:0];
        ovf      = 1'b0;
        if (sum_wide > SAT_MAX) begin
            sum = SAT_MAX[ACC_W-1:0];
            ovf = 1'b1;
        end else if (sum_wide < SAT_MIN) begin
            sum = SAT_MIN[ACC_W-1:0];
            ovf = 1'b1;
        end
    end
endmodule

// File: rtl/smac_accum.sv
// smac_accum: sums LEN consecutive signed products into one saturated result
// and presents it downstream over a valid/ready handshake.
//   clk    in  rising-edge clock
//   rst_n  in  synchronous active-low reset
//   bus    slave side of smac_accum_if:
//            start/p_in/p_valid/acc_ready in, p_ready/acc_out/acc_valid/busy/ovf out
module smac_accum
    import smac_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int LEN    = 4,
    parameter int ACC_W  = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    smac_accum_if.slave   bus
);
    localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

    logic [1:0]              state_q, state_d;
    logic [7:0]              count_q, count_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    ovf_q, ovf_d;

    logic signed [ACC_W-1:0] add_sum;
    logic                    add_ovf;
    logic                    xfer;

    sat_add #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_sat_add (
        .a   (acc_q),
        .b   (bus.p_in),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    assign xfer = (state_q == S_ACC) && bus.p_valid;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_ACC;
                    count_d = 8'd0;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            S_ACC: begin
                if (xfer) begin
                    // Later products continue from the clamped value; ovf is sticky.
                    acc_d   = add_sum;
                    ovf_d   = ovf_q | add_ovf;
                    count_d = count_q + 8'd1;
                    if (count_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // start is deliberately not looked at here, even with acc_ready.
                if (bus.acc_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= 8'd0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.p_ready   = (state_q == S_ACC);
    assign bus.busy      = (state_q == S_ACC);
    assign bus.acc_valid = (state_q == S_DONE);
    assign bus.acc_out   = acc_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_smac_accum.sv
// tb_smac_accum: self-checking bench for smac_accum.
//   dut 0: LEN=4, ACC_W=10   dut 1: LEN=4, ACC_W=8   dut 2: LEN=1, ACC_W=10
// Expected results are pushed to a scoreboard when a run is started and
// popped by a monitor when the result is handed off downstream.
module tb_smac_accum;
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    smac_accum_if #(.PROD_W(8), .ACC_W(10)) if_a ();
    smac_accum_if #(.PROD_W(8), .ACC_W(8))  if_b ();
    smac_accum_if #(.PROD_W(8), .ACC_W(10)) if_c ();

    smac_accum #(.PROD_W(8), .LEN(4), .ACC_W(10)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    smac_accum #(.PROD_W(8), .LEN(4), .ACC_W(8))  u_dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
    smac_accum #(.PROD_W(8), .LEN(1), .ACC_W(10)) u_dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

    // Stimulus side, shared p_in, per-dut controls.
    logic       start_v     [3];
    logic       p_valid_v   [3];
    logic       acc_ready_v [3];
    logic [7:0] p_in_v;

    assign if_a.start = start_v[0];  assign if_b.start = start_v[1];  assign if_c.start = start_v[2];
    assign if_a.p_valid = p_valid_v[0];  assign if_b.p_valid = p_valid_v[1];  assign if_c.p_valid = p_valid_v[2];
    assign if_a.acc_ready = acc_ready_v[0];  assign if_b.acc_ready = acc_ready_v[1];  assign if_c.acc_ready = acc_ready_v[2];
    assign if_a.p_in = p_in_v;  assign if_b.p_in = p_in_v;  assign if_c.p_in = p_in_v;

    // Observation side, widened to int-sized values.
    logic signed [31:0] acc_obs       [3];
    logic               acc_valid_obs [3];
    logic               p_ready_obs   [3];
    logic               busy_obs      [3];
    logic               ovf_obs       [3];

    assign acc_obs[0] = 32'(signed'(if_a.acc_out));
    assign acc_obs[1] = 32'(signed'(if_b.acc_out));
    assign acc_obs[2] = 32'(signed'(if_c.acc_out));
    assign acc_valid_obs[0] = if_a.acc_valid;  assign acc_valid_obs[1] = if_b.acc_valid;  assign acc_valid_obs[2] = if_c.acc_valid;
    assign p_ready_obs[0] = if_a.p_ready;  assign p_ready_obs[1] = if_b.p_ready;  assign p_ready_obs[2] = if_c.p_ready;
    assign busy_obs[0] = if_a.busy;  assign busy_obs[1] = if_b.busy;  assign busy_obs[2] = if_c.busy;
    assign ovf_obs[0] = if_a.ovf;  assign ovf_obs[1] = if_b.ovf;  assign ovf_obs[2] = if_c.ovf;

    typedef struct {
        int idx;
        int acc;
        int ovf;
    } exp_t;

    exp_t sb_q[$];
    int   stim_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Saturating reference sum of stim_q for a given accumulator width.
    function automatic void model(input int acc_w, output int acc, output int ovf);
        int mx;
        int mn;
        mx  = (1 << (acc_w - 1)) - 1;
        mn  = -(1 << (acc_w - 1));
        acc = 0;
        ovf = 0;
        foreach (stim_q[i]) begin
            acc = acc + stim_q[i];
            if (acc > mx) begin acc = mx; ovf = 1; end
            if (acc < mn) begin acc = mn; ovf = 1; end
        end
    endfunction

    // Result monitor: compares on every downstream handshake.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst_n && acc_valid_obs[k] && acc_ready_v[k]) begin
                if (sb_q.size() == 0) begin
                    check_val("sb_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    $display("result dut%0d acc_out=%0d ovf=%0d (exp %0d/%0d)",
                             k, acc_obs[k], ovf_obs[k], e.acc, e.ovf);
                    check_val("sb_dut", k, e.idx);
                    check_val("sb_acc_out", acc_obs[k], e.acc);
                    check_val("sb_ovf", 32'(ovf_obs[k]), e.ovf);
                end
            end
        end
    end

    // One full run on dut idx with the products in stim_q. Entered and left
    // #1 after a rising edge.
    task automatic run(input int idx, input int acc_w, input int gap,
                       input int hold, input bit start_with_ready);
        exp_t e;
        int   held;
        start_v[idx] = 1'b1;
        @(posedge clk); #1;
        start_v[idx] = 1'b0;
        check_val("busy_after_start", 32'(busy_obs[idx]), 1);
        check_val("ovf_cleared", 32'(ovf_obs[idx]), 0);
        e.idx = idx;
        model(acc_w, e.acc, e.ovf);
        sb_q.push_back(e);
        for (int i = 0; i < stim_q.size(); i++) begin
            p_in_v         = 8'(stim_q[i]);
            p_valid_v[idx] = 1'b1;
            check_val("p_ready_acc", 32'(p_ready_obs[idx]), 1);
            @(posedge clk); #1;
            p_valid_v[idx] = 1'b0;
            if (i < stim_q.size() - 1) begin
                check_val("valid_early", 32'(acc_valid_obs[idx]), 0);
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk); #1;
                    check_val("gap_valid", 32'(acc_valid_obs[idx]), 0);
                    check_val("gap_busy", 32'(busy_obs[idx]), 1);
                end
            end
        end
        check_val("latency_valid", 32'(acc_valid_obs[idx]), 1);
        check_val("done_p_ready", 32'(p_ready_obs[idx]), 0);
        held = acc_obs[idx];
        for (int h = 0; h < hold; h++) begin
            start_v[idx] = 1'b1;
            @(posedge clk); #1;
            check_val("bp_valid", 32'(acc_valid_obs[idx]), 1);
            check_val("bp_stable", acc_obs[idx], held);
            check_val("bp_p_ready", 32'(p_ready_obs[idx]), 0);
            check_val("bp_busy", 32'(busy_obs[idx]), 0);
        end
        start_v[idx]     = start_with_ready;
        acc_ready_v[idx] = 1'b1;
        @(posedge clk); #1;
        acc_ready_v[idx] = 1'b0;
        start_v[idx]     = 1'b0;
        check_val("release_valid", 32'(acc_valid_obs[idx]), 0);
        check_val("release_busy", 32'(busy_obs[idx]), 0);
        check_val("release_hold", acc_obs[idx], held);
        if (start_with_ready) begin
            @(posedge clk); #1;
            check_val("no_restart_busy", 32'(busy_obs[idx]), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            start_v[k] = 1'b0;
            p_valid_v[k] = 1'b0;
            acc_ready_v[k] = 1'b0;
        end
        p_in_v = 8'd0;
        rst_n  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check_val("rst_acc_out", acc_obs[k], 0);
            check_val("rst_acc_valid", 32'(acc_valid_obs[k]), 0);
            check_val("rst_p_ready", 32'(p_ready_obs[k]), 0);
            check_val("rst_busy", 32'(busy_obs[k]), 0);
            check_val("rst_ovf", 32'(ovf_obs[k]), 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Multiplier product stream, back to back then with gaps.
        stim_q = '{-7, -6, -40, 1};
        run(0, 10, 0, 0, 1'b0);
        run(0, 10, 2, 0, 1'b0);

        // Positive then negative saturation on the 8-bit accumulator.
        stim_q = '{64, 64, 64, 64};
        run(1, 8, 0, 0, 1'b0);
        stim_q = '{-64, -64, -64, -64};
        run(1, 8, 0, 0, 1'b0);

        // Backpressure with start asserted during DONE.
        stim_q = '{-7, -6, -40, 1};
        run(0, 10, 0, 5, 1'b0);

        // Reset after two accepts.
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        p_valid_v[0] = 1'b1;
        p_in_v = 8'(-7);
        @(posedge clk); #1;
        p_in_v = 8'(-6);
        @(posedge clk); #1;
        p_valid_v[0] = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_val("midrst_acc_out", acc_obs[0], 0);
        check_val("midrst_acc_valid", 32'(acc_valid_obs[0]), 0);
        check_val("midrst_p_ready", 32'(p_ready_obs[0]), 0);
        check_val("midrst_busy", 32'(busy_obs[0]), 0);
        check_val("midrst_ovf", 32'(ovf_obs[0]), 0);
        stim_q = '{3, -35, -20, -36};
        run(0, 10, 0, 0, 1'b0);

        // LEN=1, start together with acc_ready in DONE.
        stim_q = '{-42};
        run(2, 10, 0, 0, 1'b1);

        repeat (2) @(posedge clk);
        #1;
        check_val("sb_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
